// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake and operand/result bus for the bit-serial adder.
// Handshake: the requester raises start with a/b/cin valid; the controller
// takes them on the first rising edge it sees start while idle (busy=0,
// done=0). There is no back-pressure beyond that: start seen while busy or
// during the done cycle is dropped, not queued. done is a one-cycle pulse
// marking sum/cout/ovf valid; those stay put until the next done pulse.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [1:0]       dbg_state;

    // Requester side: drives the request, observes results and state.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf, dbg_state
    );

    // Controller side.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf, dbg_state
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell adds two WIDTH-bit
// operands LSB first, one bit per clock, with a start/done handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    // The only adder in the block; everything else just feeds it one bit pair
    // per cycle and collects its outputs.
    FULLADDER u_fa (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_carry),
        .o_s  (w_fa_sum),
        .o_co (w_fa_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Sequencer and datapath: capture on accepted start, shift during RUN,
    // publish the result on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh   <= bus.a;
                        r_b_sh   <= bus.b;
                        r_carry  <= bus.cin;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result <= {w_fa_sum, r_result[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // On the MSB step r_carry is the carry into the MSB and
                        // w_fa_cout the carry out of it; their XOR is signed
                        // overflow.
                        r_sum   <= {w_fa_sum, r_result[WIDTH-1:1]};
                        r_cout  <= w_fa_cout;
                        r_ovf   <= r_carry ^ w_fa_cout;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is decoded from state; results come straight from flops.
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.dbg_state = r_state;
endmodule

// Gate-level full adder cell. In silicon the sum path is one XOR deep after
// the propagate term and the carry path is AND then OR, so carry settles last.
module FULLADDER (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    logic w_p;
    logic w_g;
    logic w_t;

    xor u_x0 (w_p, i_a, i_b);
    xor u_x1 (o_s, w_p, i_ci);
    and u_a0 (w_g, i_a, i_b);
    and u_a1 (w_t, w_p, i_ci);
    or  u_o0 (o_co, w_g, w_t);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ns
// Directed bench for serial_adder_ctrl (WIDTH=8, 50 ns clock).
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation: request on a negedge, accepted at the next posedge, then
  // watch W+3 cycles. Negedge i sits between accept edge + (i-1) and + i, so
  // busy should be seen on i=1..W and done on i=W+1 (accept edge plus W more
  // edges: nine edges counting the accept edge itself for W=8).
  // With inject=1 a start with all-ones operands is pulsed during RUN cycle 3.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf, input bit inject);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [W-1:0] s_sum;
    logic s_cout;
    logic s_ovf;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    s_sum    = '0;
    s_cout   = 1'b0;
    s_ovf    = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.cin   = icin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom_range(0, 255));
    bus.b     = W'($urandom_range(0, 255));
    bus.cin   = 1'($urandom_range(0, 1));
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          s_sum   = bus.sum;
          s_cout  = bus.cout;
          s_ovf   = bus.ovf;
        end
      end
      if (inject && i == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk({tag, ".busy_cycles"}, busy_cnt, W);
    chk({tag, ".done_pulses"}, done_cnt, 1);
    chk({tag, ".done_latency"}, done_at, W + 1);
    chk({tag, ".sum"}, s_sum, e_sum);
    chk({tag, ".cout"}, s_cout, e_cout);
    chk({tag, ".ovf"}, s_ovf, e_ovf);
    // result must still be held once back in IDLE
    chk({tag, ".sum_held"}, bus.sum, e_sum);
    chk({tag, ".idle"}, bus.dbg_state, 2'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'hA5;
    bus.cin   = 1'b1;

    // reset held two cycles with start asserted: nothing may move
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", bus.busy, 0);
    chk("rst.done", bus.done, 0);
    chk("rst.sum", bus.sum, 8'h00);
    chk("rst.cout", bus.cout, 0);
    chk("rst.ovf", bus.ovf, 0);
    chk("rst.state", bus.dbg_state, 2'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    chk("rst.release_idle", bus.dbg_state, 2'd0);

    // hand-computed sums
    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("cin_only",  8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("ign_start", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);

    // set cout/ovf so the asynchronous clear is visible
    run_op("pre_rst",   8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1, 1'b0);

    // reset in the middle of RUN: accept, run 4 cycles, pull rst_n between edges
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.busy_before", bus.busy, 1);
    #5;
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", bus.busy, 0);
    chk("midrst.done", bus.done, 0);
    chk("midrst.sum", bus.sum, 8'h00);
    chk("midrst.cout", bus.cout, 0);
    chk("midrst.ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.idle", bus.dbg_state, 2'd0);
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "time bound exceeded");
  end
endmodule
